// File: rtl/rect_cmd_sequencer_pkg.sv
// Shared types for the rectangle command sequencer: FSM encoding, command layout, screen limits.
// Reject rule lives here so every consumer applies the same admission test.
package rect_cmd_sequencer_pkg;

    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int W_W     = 9;
    localparam int H_W     = 8;
    localparam int COLOR_W = 3;
    localparam int CMD_W   = X_W + Y_W + W_W + H_W + COLOR_W + 1 + COLOR_W;

    localparam int SCREEN_W_DEF = 320;
    localparam int SCREEN_H_DEF = 240;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [W_W-1:0]     w;
        logic [H_W-1:0]     h;
        logic [COLOR_W-1:0] back;
        logic               border;
        logic [COLOR_W-1:0] bcolor;
    } cmd_t;

    // Degenerate or off-screen rectangles are never worth queueing.
    function automatic logic cmd_reject(input cmd_t c, input int scr_w, input int scr_h);
        return (c.w == '0) || (c.h == '0) || (int'(c.x) >= scr_w) || (int'(c.y) >= scr_h);
    endfunction

endpackage

// File: rtl/rect_cmd_sequencer_if.sv
// Command channel plus renderer control/attribute and status signals of the sequencer.
// master = command source / renderer side, slave = sequencer.
interface rect_cmd_sequencer_if;
    import rect_cmd_sequencer_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [X_W-1:0]     cmd_x;
    logic [Y_W-1:0]     cmd_y;
    logic [W_W-1:0]     cmd_w;
    logic [H_W-1:0]     cmd_h;
    logic [COLOR_W-1:0] cmd_back;
    logic               cmd_border;
    logic [COLOR_W-1:0] cmd_bcolor;

    logic               rect_enable;
    logic [X_W-1:0]     origin_x;
    logic [Y_W-1:0]     origin_y;
    logic [W_W-1:0]     width;
    logic [H_W-1:0]     height;
    logic [COLOR_W-1:0] back_color;
    logic               border;
    logic [COLOR_W-1:0] border_color;
    logic               rect_done;

    logic               busy;
    logic [7:0]         drop_count;
    logic [15:0]        rects_drawn;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_back, cmd_border, cmd_bcolor, rect_done,
        input  cmd_ready, rect_enable, origin_x, origin_y, width, height, back_color, border,
               border_color, busy, drop_count, rects_drawn
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_back, cmd_border, cmd_bcolor, rect_done,
        output cmd_ready, rect_enable, origin_x, origin_y, width, height, back_color, border,
               border_color, busy, drop_count, rects_drawn
    );

endinterface

// File: rtl/rect_cmd_sequencer_cmd_fifo.sv
// Generic FIFO, combinational read of the head entry; a write is visible at dout the cycle after.
// Backpressure: full blocks push, empty blocks pop; simultaneous push and pop keep occupancy.
module cmd_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_wr_en = push && !full;
    assign w_rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

    // Extra pointer bit separates the full and empty cases when indices match.
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/rect_cmd_sequencer.sv
// Queues rectangle commands and sequences them into the renderer, one enable window per rectangle.
// Latency push->enable 3 cycles; cmd_ready drops when the queue is full or in reset.
module rect_cmd_sequencer
    import rect_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    rect_cmd_sequencer_if.slave  bus
);
    state_t      r_state;
    state_t      w_state_nxt;
    cmd_t        w_cmd_in;
    cmd_t        w_cmd_head;
    cmd_t        r_attr;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_store;
    logic        w_reject;
    logic        w_pop;
    logic        w_done;
    logic        r_rect_enable;
    logic        r_run_first;
    logic [7:0]  r_drop_count;
    logic [15:0] r_rects_drawn;

    assign w_cmd_in = {bus.cmd_x, bus.cmd_y, bus.cmd_w, bus.cmd_h,
                       bus.cmd_back, bus.cmd_border, bus.cmd_bcolor};

    assign bus.cmd_ready = !w_full && !reset;
    assign w_push        = bus.cmd_valid && bus.cmd_ready;
    assign w_reject      = cmd_reject(w_cmd_in, SCREEN_W, SCREEN_H);
    assign w_store       = w_push && !w_reject;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_store),
        .pop   (w_pop),
        .din   (w_cmd_in),
        .dout  (w_cmd_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (!w_empty) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_RUN;
            ST_RUN:  if (!r_run_first && bus.rect_done) w_state_nxt = ST_GAP;
            ST_GAP:  w_state_nxt = w_empty ? ST_IDLE : ST_LOAD;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The renderer's done is stale during its first enabled cycle, so it is masked then.
    always_comb begin
        w_pop  = ((r_state == ST_IDLE) || (r_state == ST_GAP)) && !w_empty;
        w_done = (r_state == ST_RUN) && !r_run_first && bus.rect_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rect_enable <= 1'b0;
            r_run_first   <= 1'b0;
            r_attr        <= '0;
            r_drop_count  <= '0;
            r_rects_drawn <= '0;
        end else begin
            r_rect_enable <= (w_state_nxt == ST_RUN);
            r_run_first   <= (r_state == ST_LOAD);
            if (w_pop) r_attr <= w_cmd_head;
            if (w_done) r_rects_drawn <= r_rects_drawn + 16'd1;
            if (w_push && w_reject && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign bus.rect_enable  = r_rect_enable;
    assign bus.origin_x     = r_attr.x;
    assign bus.origin_y     = r_attr.y;
    assign bus.width        = r_attr.w;
    assign bus.height       = r_attr.h;
    assign bus.back_color   = r_attr.back;
    assign bus.border       = r_attr.border;
    assign bus.border_color = r_attr.bcolor;
    assign bus.busy         = (r_state != ST_IDLE) || !w_empty;
    assign bus.drop_count   = r_drop_count;
    assign bus.rects_drawn  = r_rects_drawn;

endmodule

// File: tb/tb_rect_cmd_sequencer.sv
// Scoreboarded bench: pushes record expected draws, a monitor checks each enable window in order.
module tb_rect_cmd_sequencer;
    import rect_cmd_sequencer_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    rect_cmd_sequencer_if bus();

    rect_cmd_sequencer #(.DEPTH(4), .SCREEN_W(320), .SCREEN_H(240)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   n_rise = 0;
    int   push_cyc = 0;
    int   exp_drop = 0;
    int   exp_drawn = 0;
    cmd_t exp_q[$];
    int   rise_q[$];
    int   fall_q[$];
    logic tb_done = 1'b0;
    logic rnd_en  = 1'b0;
    logic r_rnd   = 1'b0;
    bit   prev_en = 1'b0;

    assign bus.rect_done = rnd_en ? r_rnd : tb_done;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) r_rnd <= 1'($urandom_range(0, 1));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Monitor: every rising enable must present the oldest outstanding accepted command.
    always @(negedge clk) begin
        cmd_t act;
        cmd_t exp;
        if (bus.rect_enable && !prev_en) begin
            n_rise++;
            rise_q.push_back(cyc);
            act = {bus.origin_x, bus.origin_y, bus.width, bus.height,
                   bus.back_color, bus.border, bus.border_color};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_draw: got attrs %h, required no draw", act);
            end else begin
                exp = exp_q.pop_front();
                check("draw_attrs", 64'(act), 64'(exp));
            end
        end
        if (!bus.rect_enable && prev_en) fall_q.push_back(cyc);
        prev_en = bus.rect_enable;
    end

    function automatic cmd_t mk(input int x, input int y, input int w, input int h,
                                input int b, input int bd, input int bc);
        cmd_t c;
        c.x = 9'(x); c.y = 8'(y); c.w = 9'(w); c.h = 8'(h);
        c.back = 3'(b); c.border = 1'(bd); c.bcolor = 3'(bc);
        return c;
    endfunction

    function automatic bit is_reject(input cmd_t c);
        return (c.w == 0) || (c.h == 0) || (c.x >= 320) || (c.y >= 240);
    endfunction

    // Called and returns at posedge+1; offers c for up to max_wait cycles.
    task automatic push(input cmd_t c, input int max_wait, output bit ok);
        bus.cmd_x = c.x; bus.cmd_y = c.y; bus.cmd_w = c.w; bus.cmd_h = c.h;
        bus.cmd_back = c.back; bus.cmd_border = c.border; bus.cmd_bcolor = c.bcolor;
        bus.cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                push_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        if (ok) begin
            if (is_reject(c)) begin
                if (exp_drop < 255) exp_drop++;
            end else begin
                exp_q.push_back(c);
                exp_drawn++;
            end
        end
    endtask

    task automatic wait_rise(input int target, input int max, input string name);
        int n = 0;
        while (n_rise < target && n < max) begin
            @(negedge clk); #1;
            n++;
        end
        if (n_rise < target) begin
            checks++; errors++;
            $display("FAIL %s: rect_enable did not rise within %0d cycles", name, max);
        end
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while (bus.busy && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy) begin
            checks++; errors++;
            $display("FAIL %s: busy still high after %0d cycles", name, max);
        end
    endtask

    task automatic do_reset();
        bus.cmd_valid = 1'b0; tb_done = 1'b0; rnd_en = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_ready", bus.cmd_ready, 0);
        check("rst_enable", bus.rect_enable, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_drop", bus.drop_count, 0);
        check("rst_drawn", bus.rects_drawn, 0);
        check("rst_attrs", {bus.origin_x, bus.origin_y, bus.width, bus.height,
                            bus.back_color, bus.border, bus.border_color}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete(); exp_drop = 0; exp_drawn = 0;
        @(negedge clk);
        check("ready_after_reset", bus.cmd_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int start;
        int acc;
        int timeouts;
        cmd_t c;
        bus.cmd_valid = 1'b0; bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0;
        bus.cmd_back = '0; bus.cmd_border = 1'b0; bus.cmd_bcolor = '0;

        // Single command, done after 20 enabled cycles
        do_reset();
        start = n_rise; rise_q.delete(); fall_q.delete();
        push(mk(10, 20, 5, 4, 3, 1, 6), 2, ok);
        check("s2_accept", ok, 1);
        wait_rise(start + 1, 10, "s2_rise");
        if (rise_q.size() > 0) check("s2_latency", rise_q[0] - push_cyc, 3);
        repeat (20) @(posedge clk);
        #1 tb_done = 1'b1;
        @(posedge clk); #1 tb_done = 1'b0;
        @(negedge clk);
        check("s2_enable_fall", bus.rect_enable, 0);
        check("s2_drawn", bus.rects_drawn, 1);
        repeat (4) @(negedge clk);
        check("s2_idle_busy", bus.busy, 0);
        check("s2_hold_x", bus.origin_x, 10);
        check("s2_hold_w", bus.width, 5);

        // Three back-to-back commands with done tied high
        do_reset();
        tb_done = 1'b1; start = n_rise; rise_q.delete(); fall_q.delete();
        for (int i = 0; i < 3; i++) push(mk(30 * i + 1, 10 + i, 4 + i, 2 + i, i, i % 2, 7 - i), 2, ok);
        wait_idle(100, "s3_idle");
        check("s3_rises", n_rise - start, 3);
        if (rise_q.size() == 3 && fall_q.size() == 3) begin
            for (int i = 0; i < 3; i++) check("s3_run_len", fall_q[i] - rise_q[i], 2);
            for (int i = 0; i < 2; i++) check("s3_gap_len", rise_q[i + 1] - fall_q[i], 2);
        end
        check("s3_drawn", bus.rects_drawn, 3);

        // Reject rules, then one valid command
        do_reset();
        tb_done = 1'b1; start = n_rise;
        push(mk(5, 5, 0, 3, 1, 0, 1), 2, ok);
        push(mk(320, 5, 3, 3, 1, 0, 1), 2, ok);
        push(mk(5, 240, 3, 3, 1, 0, 1), 2, ok);
        push(mk(100, 50, 7, 7, 2, 0, 5), 2, ok);
        wait_idle(50, "s4_idle");
        check("s4_drop", bus.drop_count, 3);
        check("s4_rises", n_rise - start, 1);
        check("s4_drawn", bus.rects_drawn, 1);

        // Reset in the third RUN cycle with two commands queued
        tb_done = 1'b0; start = n_rise;
        for (int i = 0; i < 3; i++) push(mk(50 + i, 60, 8, 8, 1, 1, 2), 2, ok);
        wait_rise(start + 1, 10, "s6_rise");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete(); exp_drop = 0; exp_drawn = 0;
        @(negedge clk);
        check("s6_enable", bus.rect_enable, 0);
        check("s6_busy", bus.busy, 0);
        check("s6_drop", bus.drop_count, 0);
        check("s6_drawn", bus.rects_drawn, 0);
        start = n_rise;
        repeat (30) @(negedge clk);
        check("s6_no_enable", n_rise - start, 0);

        // Queue depth: one running plus four stored
        do_reset();
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            push(mk(20 + i, 30 + i, 6, 6, i, 0, i), 1, ok);
            acc += int'(ok);
        end
        check("s5_accepts", acc, 5);
        c = mk(99, 99, 9, 9, 7, 1, 7);
        push(c, 3, ok);
        check("s5_sixth_blocked", ok, 0);
        @(negedge clk);
        check("s5_ready_low", bus.cmd_ready, 0);
        @(posedge clk); #1 tb_done = 1'b1;
        @(posedge clk); #1 tb_done = 1'b0;
        push(c, 4, ok);
        check("s5_sixth_accepted", ok, 1);
        tb_done = 1'b1;
        wait_idle(200, "s5_idle");
        check("s5_drawn", bus.rects_drawn, 6);
        check("s5_queue_empty", exp_q.size(), 0);

        // Drop counter saturation
        do_reset();
        tb_done = 1'b1; start = n_rise;
        for (int i = 0; i < 300; i++) begin
            case (i % 3)
                0:       c = mk($urandom_range(0, 319), $urandom_range(0, 239), 0, 4, 1, 0, 1);
                1:       c = mk(320 + $urandom_range(0, 191), 10, 4, 4, 1, 0, 1);
                default: c = mk(10, 240 + $urandom_range(0, 15), 4, 4, 1, 0, 1);
            endcase
            push(c, 2, ok);
        end
        check("s7_drop_sat", bus.drop_count, 255);
        check("s7_drop_model", bus.drop_count, exp_drop);
        check("s7_no_draw", n_rise - start, 0);

        // Randomised traffic with random done
        do_reset();
        rnd_en = 1'b1; start = n_rise; timeouts = 0;
        for (int i = 0; i < 60; i++) begin
            c = mk($urandom_range(0, 339), $urandom_range(0, 249), $urandom_range(0, 24),
                   $urandom_range(0, 12), $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7));
            push(c, 60, ok);
            if (!ok) timeouts++;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        rnd_en = 1'b0; tb_done = 1'b1;
        wait_idle(400, "s8_idle");
        check("s8_timeouts", timeouts, 0);
        check("s8_drop", bus.drop_count, exp_drop);
        check("s8_drawn", bus.rects_drawn, exp_drawn);
        check("s8_rises", n_rise - start, exp_drawn);
        check("s8_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
